// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 MIPS general-purpose register file with $0 hard-wired to zero
module register_file #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter bit          BYPASS  = 1'b1,
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int SP_IX = 29;

    // $0 has no storage; only indices 1..NREG-1 are flops
    logic [DATA_W-1:0] regs [1:NREG-1];

    // A write only takes effect outside reset and never targets $0; the same
    // qualifier gates the bypass so reset cycles never forward write data.
    logic wr_active;
    assign wr_active = resetN && regWrite && (writeReg != '0);

    // Storage update: reset clears everything (except $sp) and wins over a write
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 1; i < NREG; i++) begin
                if (i == SP_IX)
                    regs[i] <= SP_INIT[DATA_W-1:0];
                else
                    regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[writeReg] <= writeData;
        end
    end

    // Read port 1: $0 reads zero, optional same-cycle forwarding of the write
    always_comb begin
        readData1 = '0;
        if (readReg1 != '0) begin
            if (BYPASS && wr_active && (writeReg == readReg1))
                readData1 = writeData;
            else
                readData1 = regs[readReg1];
        end
    end

    // Read port 2: identical to port 1, driven by readReg2
    always_comb begin
        readData2 = '0;
        if (readReg2 != '0) begin
            if (BYPASS && wr_active && (writeReg == readReg2))
                readData2 = writeData;
            else
                readData2 = regs[readReg2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and model-checked bench for register_file
module tb_register_file;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        regWrite = 1'b0;
    logic [4:0]  writeReg = '0;
    logic [31:0] writeData = '0;
    logic [4:0]  readReg1 = '0;
    logic [4:0]  readReg2 = '0;
    logic [31:0] rd1_b, rd2_b;   // BYPASS=1 instance
    logic [31:0] rd1_n, rd2_n;   // BYPASS=0 instance

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m [0:31];

    always #5 clk = ~clk;

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .SP_INIT(SP)) dut (
        .clk(clk), .resetN(resetN), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_b), .readData2(rd2_b)
    );

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .SP_INIT(SP)) dut_nb (
        .clk(clk), .resetN(resetN), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_n), .readData2(rd2_n)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'd0;
        if (byp && resetN && regWrite && writeReg != 5'd0 && writeReg == idx) return writeData;
        return m[idx];
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 32; i++) m[i] = (i == 29) ? SP : 32'd0;
    endtask

    task automatic test_reset;
        resetN = 1'b0; regWrite = 1'b0;
        tick();
        resetN = 1'b1;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1, e2;
            readReg1 = 5'(i); readReg2 = 5'(31 - i);
            e1 = (i == 29) ? SP : 32'd0;
            e2 = ((31 - i) == 29) ? SP : 32'd0;
            #1;
            vectors++;
            if (rd1_b !== e1 || rd2_b !== e2 || rd1_n !== e1 || rd2_n !== e2) begin
                errors++;
                $display("FAIL reset idx=%0d: got %h %h / %h %h, want %h %h",
                         i, rd1_b, rd2_b, rd1_n, rd2_n, e1, e2);
            end
        end
    endtask

    task automatic test_write_read;
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'd100;
        tick();
        writeReg = 5'd6; writeData = 32'd500;
        tick();
        regWrite = 1'b0; readReg1 = 5'd5; readReg2 = 5'd6;
        m[5] = 32'd100; m[6] = 32'd500;
        #1;
        vectors++;
        if (rd1_b !== 32'd100 || rd2_b !== 32'd500 || rd1_n !== 32'd100 || rd2_n !== 32'd500) begin
            errors++;
            $display("FAIL write_read: got %0d %0d / %0d %0d, want 100 500", rd1_b, rd2_b, rd1_n, rd2_n);
        end
        vectors++;
        if (rd1_b + rd2_b !== 32'd600) begin
            errors++;
            $display("FAIL alu_add: got %0d, want 600", rd1_b + rd2_b);
        end
    endtask

    task automatic test_zero_guard;
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hDEADBEEF;
        readReg1 = 5'd0; readReg2 = 5'd0;
        #1;
        vectors++;
        if (rd1_b !== 32'd0 || rd2_b !== 32'd0 || rd1_n !== 32'd0 || rd2_n !== 32'd0) begin
            errors++;
            $display("FAIL zero_pre: got %h %h / %h %h, want 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
        tick();
        regWrite = 1'b0;
        #1;
        vectors++;
        if (rd1_b !== 32'd0 || rd2_b !== 32'd0 || rd1_n !== 32'd0 || rd2_n !== 32'd0) begin
            errors++;
            $display("FAIL zero_post: got %h %h / %h %h, want 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_bypass;
        regWrite = 1'b1; writeReg = 5'd7; writeData = 32'd3;
        tick();
        writeData = 32'd9; readReg1 = 5'd7; readReg2 = 5'd7;
        #1;
        vectors++;
        if (rd1_b !== 32'd9 || rd2_b !== 32'd9) begin
            errors++;
            $display("FAIL bypass_on: got %0d %0d, want 9 9", rd1_b, rd2_b);
        end
        vectors++;
        if (rd1_n !== 32'd3 || rd2_n !== 32'd3) begin
            errors++;
            $display("FAIL bypass_off_pre: got %0d %0d, want 3 3", rd1_n, rd2_n);
        end
        tick();
        regWrite = 1'b0; m[7] = 32'd9;
        #1;
        vectors++;
        if (rd1_b !== 32'd9 || rd2_b !== 32'd9 || rd1_n !== 32'd9 || rd2_n !== 32'd9) begin
            errors++;
            $display("FAIL bypass_post: got %0d %0d / %0d %0d, want 9", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_reset_vs_write;
        regWrite = 1'b1; writeReg = 5'd8; writeData = 32'd42;
        tick();
        resetN = 1'b0; writeData = 32'd77; readReg1 = 5'd8; readReg2 = 5'd29;
        #1;
        vectors++;
        if (rd1_b !== 32'd42 || rd1_n !== 32'd42 || rd2_b !== SP) begin
            errors++;
            $display("FAIL reset_nobypass: got %0d %0d sp=%h, want 42 42 sp=%h", rd1_b, rd1_n, rd2_b, SP);
        end
        tick();
        resetN = 1'b1; regWrite = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (rd1_b !== 32'd0 || rd1_n !== 32'd0 || rd2_b !== SP || rd2_n !== SP) begin
            errors++;
            $display("FAIL reset_over_write: got %0d %0d sp=%h %h, want 0 0 sp=%h", rd1_b, rd1_n, rd2_b, rd2_n, SP);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 1000; c++) begin
            logic [31:0] e1b, e2b, e1n, e2n;
            resetN    = ($urandom_range(0, 49) != 0);
            regWrite  = $urandom_range(0, 1);
            writeReg  = 5'($urandom_range(0, 31));
            writeData = $urandom;
            readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            readReg2  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            e1b = model_rd(readReg1, 1'b1); e2b = model_rd(readReg2, 1'b1);
            e1n = model_rd(readReg1, 1'b0); e2n = model_rd(readReg2, 1'b0);
            #1;
            vectors++;
            if (rd1_b !== e1b || rd2_b !== e2b || rd1_n !== e1n || rd2_n !== e2n) begin
                errors++;
                $display("FAIL random c=%0d r1=%0d r2=%0d: got %h %h / %h %h, want %h %h / %h %h",
                         c, readReg1, readReg2, rd1_b, rd2_b, rd1_n, rd2_n, e1b, e2b, e1n, e2n);
            end
            tick();
            if (!resetN) model_reset();
            else if (regWrite && writeReg != 5'd0) m[writeReg] = writeData;
        end
        resetN = 1'b1; regWrite = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_zero_guard();
        test_bypass();
        test_reset_vs_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
